hazard_stall_unit: RTL and testbench

- Producer-side counterpart to EX-stage operand forwarding in the 5-stage pipeline.
- Resolves the hazards forwarding cannot cover:
  - load-use dependencies;
  - taken branch/jump redirects resolved in EX;
  - multi-cycle data-memory accesses in M.
- Drives per-stage write-enables, bubble and flush controls.
- Runs a memory-wait FSM with a timeout watchdog.

---
 rtl/hazard_stall_unit.sv | 203 ++++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Producer-side hazard control for the 5-stage pipeline. Covers the hazards
//   that EX-stage forwarding cannot cover:
//     - load-use dependencies (one bubble into ID/EX),
//     - taken branch/jump redirects resolved in EX (flush IF/ID, bubble ID/EX),
//     - multi-cycle data-memory accesses in M (freeze, with a timeout watchdog).
//   Control outputs are combinational from the FSM state and the current inputs.
//   Priority: freeze > redirect > load-use > normal.
//
// Optional build feature: define HAZARD_STATS_EN to add the saturating
//   StallCycles, LoadUseCount and RedirectCount statistics outputs.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   ID_*                ID-stage instruction validity and source registers
//   EX_*                EX-stage destination, load flag and redirect
//   M_MemReq            M-stage instruction accesses data memory
//   DMEM_Ready          data memory completes the access this cycle
//   PC_WE .. EXM_WE     per-stage write enables
//   IFID_Flush          load NOP into IF/ID
//   IDEX_Bubble         load NOP into ID/EX
//   MWB_Bubble          load NOP into M/WB
//   MemFault            sticky memory-timeout flag
//   StallCycles, LoadUseCount, RedirectCount (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ID_Valid,
   input  logic [4:0]  ID_REG_RA1,
   input  logic [4:0]  ID_REG_RA2,
   input  logic        ID_UseRA1,
   input  logic        ID_UseRA2,
   input  logic [4:0]  EX_REG_WA,
   input  logic        EX_REG_WE,
   input  logic        EX_isLoad,
   input  logic        EX_Redirect,
   input  logic        M_MemReq,
   input  logic        DMEM_Ready,
   output logic        PC_WE,
   output logic        IFID_WE,
   output logic        IDEX_WE,
   output logic        EXM_WE,
   output logic        IFID_Flush,
   output logic        IDEX_Bubble,
   output logic        MWB_Bubble,
`ifdef HAZARD_STATS_EN
   output logic        MemFault,
   output logic [31:0] StallCycles,
   output logic [31:0] LoadUseCount,
   output logic [31:0] RedirectCount
`else
   output logic        MemFault
`endif
);

   typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_fault_q, mem_fault_d;

   logic ra1_hit, ra2_hit, load_use, mem_stall, freeze;

   // x0 is hardwired zero, so a write to it never creates a dependency.
   assign ra1_hit   = ID_UseRA1 && (ID_REG_RA1 == EX_REG_WA);
   assign ra2_hit   = ID_UseRA2 && (ID_REG_RA2 == EX_REG_WA);
   assign load_use  = ID_Valid && EX_isLoad && EX_REG_WE && (EX_REG_WA != 5'd0) &&
                      (ra1_hit || ra2_hit);
   assign mem_stall = M_MemReq && !DMEM_Ready;
   assign freeze    = (state_q == StFault) || mem_stall;

   assign MemFault = mem_fault_q;

   // Pipeline controls. A frozen cycle holds every stage and drains WB with a
   // NOP; redirect/load-use are simply re-evaluated once the freeze drops.
   always_comb begin
      PC_WE       = 1'b0;
      IFID_WE     = 1'b0;
      IDEX_WE     = 1'b0;
      EXM_WE      = 1'b0;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      MWB_Bubble  = 1'b0;
      if (!RST) begin
         if (freeze) begin
            MWB_Bubble = 1'b1;
         end else if (EX_Redirect) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            PC_WE       = 1'b1;
            IFID_WE     = 1'b1;
            IDEX_WE     = 1'b1;
            EXM_WE      = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID for one cycle; M-stage forwarding covers the rest.
            IDEX_WE     = 1'b1;
            EXM_WE      = 1'b1;
            IDEX_Bubble = 1'b1;
         end else begin
            PC_WE   = 1'b1;
            IFID_WE = 1'b1;
            IDEX_WE = 1'b1;
            EXM_WE  = 1'b1;
         end
      end
   end

   // Memory-wait FSM with timeout watchdog.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_fault_d = mem_fault_q;
      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               state_d    = StMemWait;
               wait_cnt_d = CNT_W'(1);
            end
         end
         StMemWait: begin
            // A dropped request is illegal here; recover rather than hang.
            if (!M_MemReq || DMEM_Ready) begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               state_d     = StFault;
               mem_fault_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         StFault: begin
            state_d     = StFault;
            mem_fault_d = 1'b1;
         end
         default: begin
            state_d    = StRun;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_fault_q <= mem_fault_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] load_use_cnt_q, load_use_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;
   logic        lu_taken, redirect_taken;

   assign lu_taken       = !RST && !freeze && !EX_Redirect && load_use;
   assign redirect_taken = !RST && !freeze && EX_Redirect;

   // All counters saturate instead of wrapping.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      load_use_cnt_d = load_use_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (!RST && !PC_WE && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (lu_taken && (load_use_cnt_q != 32'hFFFF_FFFF)) begin
         load_use_cnt_d = load_use_cnt_q + 32'd1;
      end
      if (redirect_taken && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
         redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cycles_q <= '0;
         load_use_cnt_q <= '0;
         redirect_cnt_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         load_use_cnt_q <= load_use_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign StallCycles   = stall_cycles_q;
   assign LoadUseCount  = load_use_cnt_q;
   assign RedirectCount = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//   Directed scenarios followed by randomized stimulus, every cycle compared
//   against a behavioural model that counts consecutive memory-wait cycles and
//   applies the freeze > redirect > load-use > normal priority directly.
//   Define HAZARD_STATS_EN to also connect and check the statistics outputs.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

   localparam int unsigned MEM_TIMEOUT = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ID_Valid;
   logic [4:0]  ID_REG_RA1, ID_REG_RA2;
   logic        ID_UseRA1, ID_UseRA2;
   logic [4:0]  EX_REG_WA;
   logic        EX_REG_WE, EX_isLoad, EX_Redirect;
   logic        M_MemReq, DMEM_Ready;
   logic        PC_WE, IFID_WE, IDEX_WE, EXM_WE;
   logic        IFID_Flush, IDEX_Bubble, MWB_Bubble, MemFault;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCycles, LoadUseCount, RedirectCount;
`endif

   hazard_stall_unit #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (5)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .ID_Valid      (ID_Valid),
      .ID_REG_RA1    (ID_REG_RA1),
      .ID_REG_RA2    (ID_REG_RA2),
      .ID_UseRA1     (ID_UseRA1),
      .ID_UseRA2     (ID_UseRA2),
      .EX_REG_WA     (EX_REG_WA),
      .EX_REG_WE     (EX_REG_WE),
      .EX_isLoad     (EX_isLoad),
      .EX_Redirect   (EX_Redirect),
      .M_MemReq      (M_MemReq),
      .DMEM_Ready    (DMEM_Ready),
      .PC_WE         (PC_WE),
      .IFID_WE       (IFID_WE),
      .IDEX_WE       (IDEX_WE),
      .EXM_WE        (EXM_WE),
      .IFID_Flush    (IFID_Flush),
      .IDEX_Bubble   (IDEX_Bubble),
      .MWB_Bubble    (MWB_Bubble),
`ifdef HAZARD_STATS_EN
      .MemFault      (MemFault),
      .StallCycles   (StallCycles),
      .LoadUseCount  (LoadUseCount),
      .RedirectCount (RedirectCount)
`else
      .MemFault      (MemFault)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model state: consecutive stalled memory cycles, sticky fault, stats.
   int          m_waited = 0;
   bit          m_fault  = 1'b0;
   longint      m_stall  = 0;
   longint      m_lu     = 0;
   longint      m_redir  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_load_use();
      bit hit;
      hit = (ID_UseRA1 && ID_REG_RA1 == EX_REG_WA) || (ID_UseRA2 && ID_REG_RA2 == EX_REG_WA);
      return ID_Valid && EX_isLoad && EX_REG_WE && (EX_REG_WA != 0) && hit;
   endfunction

   function automatic bit model_freeze();
      return m_fault || (M_MemReq && !DMEM_Ready);
   endfunction

   // {PC_WE, IFID_WE, IDEX_WE, EXM_WE, IFID_Flush, IDEX_Bubble, MWB_Bubble}
   function automatic logic [6:0] model_ctrl();
      if (RST)                   return 7'b0000_000;
      else if (model_freeze())   return 7'b0000_001;
      else if (EX_Redirect)      return 7'b1111_110;
      else if (model_load_use()) return 7'b0011_010;
      else                       return 7'b1111_000;
   endfunction

   function automatic longint sat_inc(input longint v);
      return (v >= 64'hFFFF_FFFF) ? v : v + 1;
   endfunction

   task automatic model_update();
      logic [6:0] c;
      c = model_ctrl();
      if (RST) begin
         m_waited = 0;
         m_fault  = 1'b0;
         m_stall  = 0;
         m_lu     = 0;
         m_redir  = 0;
      end else begin
         if (!c[6]) m_stall = sat_inc(m_stall);
         if (!model_freeze() && EX_Redirect) m_redir = sat_inc(m_redir);
         if (!model_freeze() && !EX_Redirect && model_load_use()) m_lu = sat_inc(m_lu);
         if (!m_fault) begin
            if (M_MemReq && !DMEM_Ready) begin
               m_waited++;
               if (m_waited >= MEM_TIMEOUT) m_fault = 1'b1;
            end else begin
               m_waited = 0;
            end
         end
      end
   endtask

   // Inputs are driven just after a falling edge; compare, advance the model,
   // then move on to the next falling edge.
   task automatic tick(input string tag);
      #1;
      chk({tag, "_ctrl"}, {25'd0, PC_WE, IFID_WE, IDEX_WE, EXM_WE, IFID_Flush, IDEX_Bubble,
                           MWB_Bubble}, {25'd0, model_ctrl()});
      chk({tag, "_fault"}, {31'd0, MemFault}, {31'd0, m_fault});
`ifdef HAZARD_STATS_EN
      chk({tag, "_stall"}, StallCycles, m_stall[31:0]);
      chk({tag, "_lu"}, LoadUseCount, m_lu[31:0]);
      chk({tag, "_redir"}, RedirectCount, m_redir[31:0]);
`endif
      model_update();
      @(negedge CLK);
   endtask

   task automatic idle();
      ID_Valid    = 1'b0;
      ID_REG_RA1  = 5'd0;
      ID_REG_RA2  = 5'd0;
      ID_UseRA1   = 1'b0;
      ID_UseRA2   = 1'b0;
      EX_REG_WA   = 5'd0;
      EX_REG_WE   = 1'b0;
      EX_isLoad   = 1'b0;
      EX_Redirect = 1'b0;
      M_MemReq    = 1'b0;
      DMEM_Ready  = 1'b1;
   endtask

   task automatic set_load_use(input logic [4:0] wa, input logic use1);
      ID_Valid   = 1'b1;
      ID_REG_RA1 = 5'd5;
      ID_REG_RA2 = 5'd9;
      ID_UseRA1  = use1;
      ID_UseRA2  = 1'b1;
      EX_REG_WA  = wa;
      EX_REG_WE  = 1'b1;
      EX_isLoad  = 1'b1;
   endtask

   initial begin
      idle();
      RST = 1'b1;
      @(negedge CLK);
      tick("reset0");
      tick("reset1");
      RST = 1'b0;
      tick("idle");

      // Load x5 in EX, ID reads x5: exactly one bubble.
      set_load_use(5'd5, 1'b1);
      #1;
      chk("lu_pc_we", {31'd0, PC_WE}, 32'd0);
      chk("lu_bubble", {31'd0, IDEX_Bubble}, 32'd1);
      tick("lu");
      EX_isLoad = 1'b0;
      EX_REG_WE = 1'b0;
      tick("lu_after");

      // Writes to x0 and unused operands never stall.
      set_load_use(5'd0, 1'b1);
      ID_REG_RA1 = 5'd0;
      tick("lu_x0");
      set_load_use(5'd5, 1'b0);
      tick("lu_nouse");

      // Redirect beats load-use.
      set_load_use(5'd5, 1'b1);
      EX_Redirect = 1'b1;
      #1;
      chk("redir_flush", {31'd0, IFID_Flush}, 32'd1);
      chk("redir_pc_we", {31'd0, PC_WE}, 32'd1);
      tick("redir");
      idle();

      // Three-cycle memory wait, then completion.
      M_MemReq   = 1'b1;
      DMEM_Ready = 1'b0;
      for (int i = 0; i < 3; i++) tick("memwait");
      DMEM_Ready = 1'b1;
      #1;
      chk("mem_done_pc_we", {31'd0, PC_WE}, 32'd1);
      tick("mem_done");
      M_MemReq = 1'b0;
      tick("mem_idle");
`ifdef HAZARD_STATS_EN
      chk("stats_stall4", StallCycles, 32'd4);
      chk("stats_lu1", LoadUseCount, 32'd1);
      chk("stats_redir1", RedirectCount, 32'd1);
`endif

      // Timeout: fault after the 16th frozen cycle, sticky until reset.
      M_MemReq   = 1'b1;
      DMEM_Ready = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         #1;
         chk("to_nofault_yet", {31'd0, MemFault}, 32'd0);
         tick("timeout");
      end
      #1;
      chk("to_fault", {31'd0, MemFault}, 32'd1);
      idle();
      #1;
      chk("fault_freeze", {31'd0, PC_WE}, 32'd0);
      for (int i = 0; i < 4; i++) tick("fault_hold");
      RST = 1'b1;
      tick("fault_rst");
      RST = 1'b0;
      #1;
      chk("post_rst_fault", {31'd0, MemFault}, 32'd0);
      chk("post_rst_pc_we", {31'd0, PC_WE}, 32'd1);
`ifdef HAZARD_STATS_EN
      chk("stats_cleared", StallCycles, 32'd0);
`endif
      tick("post_rst");

      // Randomized traffic, compared every cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         RST         = ($urandom_range(0, 199) == 0);
         ID_Valid    = ($urandom_range(0, 3) != 0);
         ID_REG_RA1  = 5'($urandom_range(0, 3));
         ID_REG_RA2  = 5'($urandom_range(0, 3));
         ID_UseRA1   = 1'($urandom_range(0, 1));
         ID_UseRA2   = 1'($urandom_range(0, 1));
         EX_REG_WA   = 5'($urandom_range(0, 3));
         EX_REG_WE   = ($urandom_range(0, 3) != 0);
         EX_isLoad   = 1'($urandom_range(0, 1));
         EX_Redirect = ($urandom_range(0, 5) == 0);
         // Long M_MemReq bursts with a slow memory occasionally reach the timeout.
         if ($urandom_range(0, 9) == 0) M_MemReq = ~M_MemReq;
         DMEM_Ready  = ($urandom_range(0, 5) == 0);
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
